// File: rtl/n2_icd_sp_param_cust.sv
// Parametrised icache data array: per-way storage, multi-beat line-fill sequencer,
// read/fill arbitration and late way select. Define ICD_PERR_EN to build the parity checker.
module n2_icd_way #(
    parameter int SETS  = 128,
    parameter int BEATS = 2,
    parameter int BW    = 132,
    parameter int SW    = 7,
    parameter int GW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [SW-1:0] widx,
    input  logic [GW-1:0] wbeat,
    input  logic [BW-1:0] wdata,
    input  logic          re,
    input  logic [SW-1:0] ridx,
    input  logic [GW-1:0] rgrp,
    output logic [BW-1:0] q
);
    // One NBUS-word group per entry, so a fill beat and a read are each a single access.
    logic [BW-1:0] mem [SETS][BEATS];

    always_ff @(posedge clk)
        if (we) mem[widx][wbeat] <= wdata;

    always_ff @(posedge clk or posedge rst)
        if (rst)     q <= '0;
        else if (re) q <= mem[ridx][rgrp];
endmodule

module n2_icd_sp_param_cust #(
    parameter int WAYS       = 8,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int NBUS       = 4,
    parameter int IW         = 33,
    localparam int BEATS = LINE_WORDS / NBUS,
    localparam int SW    = $clog2(SETS),
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int GW    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int BW    = NBUS * IW
) (
    input  logic            l2clk,
    input  logic            arst,
    input  logic            rd_req_bf,
    input  logic [SW-1:0]   rd_index_bf,
    input  logic [GW-1:0]   rd_grp_bf,
    input  logic [WAYS-1:0] waysel_c,
    input  logic            fill_start_bf,
    input  logic [SW-1:0]   fill_index_bf,
    input  logic [WW-1:0]   fill_way_bf,
    input  logic            fill_vld_bf,
    input  logic [BW-1:0]   fill_data_bf,
    output logic            fill_busy,
    output logic            fill_ovr,
    output logic [BW-1:0]   icd_instr_c,
    output logic            icd_vld_c,
    output logic            icd_nack_c,
    output logic [NBUS-1:0] icd_perr_c,
    output logic [7:0]      icd_perr_cnt
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic [SW-1:0]           f_idx;
    logic [WW-1:0]           f_way;
    logic [GW-1:0]           cnt;
    logic                    wr_beat;
    logic                    rd_en;
    logic [GW-1:0]           rd_grp;
    logic [WAYS-1:0][BW-1:0] creg;

    // A write beat always wins the single array port; the colliding read is nacked.
    assign wr_beat   = (state == FILL) && fill_vld_bf;
    assign rd_en     = rd_req_bf && !wr_beat;
    assign rd_grp    = (BEATS > 1) ? rd_grp_bf : '0;
    assign fill_busy = (state == FILL);

    always_ff @(posedge l2clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            f_idx      <= '0;
            f_way      <= '0;
            cnt        <= '0;
            fill_ovr   <= 1'b0;
            icd_vld_c  <= 1'b0;
            icd_nack_c <= 1'b0;
        end else begin
            fill_ovr   <= (state == FILL) && fill_start_bf;
            icd_vld_c  <= rd_en;
            icd_nack_c <= rd_req_bf && wr_beat;
            case (state)
                IDLE: if (fill_start_bf) begin
                    f_idx <= fill_index_bf;
                    f_way <= fill_way_bf;
                    cnt   <= '0;
                    state <= FILL;
                end
                FILL: if (fill_vld_bf) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == GW'(BEATS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        n2_icd_way #(.SETS(SETS), .BEATS(BEATS), .BW(BW), .SW(SW), .GW(GW)) u_way (
            .clk   (l2clk),
            .rst   (arst),
            .we    (wr_beat && (f_way == WW'(w))),
            .widx  (f_idx),
            .wbeat (cnt),
            .wdata (fill_data_bf),
            .re    (rd_en),
            .ridx  (rd_index_bf),
            .rgrp  (rd_grp),
            .q     (creg[w])
        );
    end

    always_comb begin
        icd_instr_c = '0;
        for (int w = 0; w < WAYS; w++)
            if (waysel_c[w]) icd_instr_c = icd_instr_c | creg[w];
    end

`ifdef ICD_PERR_EN
    logic [8:0] perr_sum;

    always_comb begin
        icd_perr_c = '0;
        for (int i = 0; i < NBUS; i++)
            icd_perr_c[i] = icd_vld_c & (^icd_instr_c[i*IW +: IW]);
    end

    assign perr_sum = {1'b0, icd_perr_cnt} + 9'($countones(icd_perr_c));

    always_ff @(posedge l2clk or posedge arst)
        if (arst) icd_perr_cnt <= '0;
        else      icd_perr_cnt <= perr_sum[8] ? 8'hff : perr_sum[7:0];
`else
    assign icd_perr_c   = '0;
    assign icd_perr_cnt = '0;
`endif
endmodule

// File: tb/tb_n2_icd_sp_param_cust.sv
// Scoreboard bench for n2_icd_sp_param_cust: stimulus pushes expectations from an
// array-of-words model, a monitor pops them whenever the c stage presents a response.
module tb_n2_icd_sp_param_cust;
    localparam int WAYS = 8, SETS = 128, LINE_WORDS = 8, NBUS = 4, IW = 33;
    localparam int BEATS = LINE_WORDS / NBUS;
    localparam int NB = NBUS * IW;
    localparam int SW = $clog2(SETS), WW = $clog2(WAYS), GW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NS = 8;
`ifdef ICD_PERR_EN
    localparam bit PERR_ON = 1'b1;
`else
    localparam bit PERR_ON = 1'b0;
`endif

    logic            l2clk = 1'b0, arst = 1'b1;
    logic            rd_req_bf, fill_start_bf, fill_vld_bf;
    logic [SW-1:0]   rd_index_bf, fill_index_bf;
    logic [GW-1:0]   rd_grp_bf;
    logic [WW-1:0]   fill_way_bf;
    logic [WAYS-1:0] waysel_c;
    logic [NB-1:0]   fill_data_bf;
    logic            fill_busy, fill_ovr, icd_vld_c, icd_nack_c;
    logic [NB-1:0]   icd_instr_c;
    logic [NBUS-1:0] icd_perr_c;
    logic [7:0]      icd_perr_cnt;

    always #5 l2clk = ~l2clk;

    n2_icd_sp_param_cust dut (
        .l2clk(l2clk), .arst(arst), .rd_req_bf(rd_req_bf), .rd_index_bf(rd_index_bf),
        .rd_grp_bf(rd_grp_bf), .waysel_c(waysel_c), .fill_start_bf(fill_start_bf),
        .fill_index_bf(fill_index_bf), .fill_way_bf(fill_way_bf), .fill_vld_bf(fill_vld_bf),
        .fill_data_bf(fill_data_bf), .fill_busy(fill_busy), .fill_ovr(fill_ovr),
        .icd_instr_c(icd_instr_c), .icd_vld_c(icd_vld_c), .icd_nack_c(icd_nack_c),
        .icd_perr_c(icd_perr_c), .icd_perr_cnt(icd_perr_cnt)
    );

    typedef struct { bit nack; logic [NB-1:0] data; } rsp_t;
    typedef struct { bit busy; bit ovr; } st_t;

    rsp_t          rsp_q[$];
    st_t           st_q[$];
    logic [IW-1:0] ref_mem [SETS][WAYS][LINE_WORDS];
    logic [NB-1:0] m_creg [WAYS];
    bit            m_busy;
    int            m_cnt, m_idx, m_way;
    int            n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] rnd_word();
        return {1'($urandom % 2), 32'($urandom)};
    endfunction

    function automatic logic [NB-1:0] sel_or(input logic [WAYS-1:0] ws);
        logic [NB-1:0] d = '0;
        for (int w = 0; w < WAYS; w++) if (ws[w]) d = d | m_creg[w];
        return d;
    endfunction

    // One bf-stage cycle: drive inputs at negedge and advance the reference model.
    task automatic drive(input bit st, input int si, input int sw, input bit fv,
                         input logic [NB-1:0] fd, input bit rq, input int ri, input int rg,
                         input logic [WAYS-1:0] ws);
        rsp_t r;
        st_t  s;
        bit   beat;
        @(negedge l2clk);
        fill_start_bf = st; fill_index_bf = SW'(si); fill_way_bf = WW'(sw);
        fill_vld_bf = fv; fill_data_bf = fd;
        rd_req_bf = rq; rd_index_bf = SW'(ri); rd_grp_bf = GW'(rg);
        beat = m_busy && fv;
        if (rq) begin
            waysel_c = ws;
            if (!beat)
                for (int w = 0; w < WAYS; w++)
                    for (int j = 0; j < NBUS; j++)
                        m_creg[w][j*IW +: IW] = ref_mem[ri][w][rg*NBUS + j];
            r.nack = beat;
            r.data = sel_or(ws);
            rsp_q.push_back(r);
        end
        s.ovr = m_busy && st;
        if (beat) begin
            for (int j = 0; j < NBUS; j++) ref_mem[m_idx][m_way][m_cnt*NBUS + j] = fd[j*IW +: IW];
            m_cnt++;
            if (m_cnt == BEATS) m_busy = 1'b0;
        end else if (!m_busy && st) begin
            m_busy = 1'b1; m_idx = si; m_way = sw; m_cnt = 0;
        end
        s.busy = m_busy;
        st_q.push_back(s);
    endtask

    task automatic idle_cyc();
        drive(0, 0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic rd(input int ri, input int rg, input logic [WAYS-1:0] ws);
        drive(0, 0, 0, 0, '0, 1, ri, rg, ws);
    endtask

    task automatic beat_cyc(input logic [NB-1:0] fd);
        drive(0, 0, 0, 1, fd, 0, 0, 0, '0);
    endtask

    // mode 0: random words, 1: 0x10+k, 2: zeros except odd-parity word 2
    task automatic fill_line(input int s, input int w, input int mode);
        logic [IW-1:0] wd [LINE_WORDS];
        logic [NB-1:0] fd;
        for (int k = 0; k < LINE_WORDS; k++)
            wd[k] = (mode == 1) ? IW'(16 + k) : (mode == 2) ? ((k == 2) ? IW'(1) : '0) : rnd_word();
        drive(1, s, w, 0, '0, 0, 0, 0, '0);
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < NBUS; j++) fd[j*IW +: IW] = wd[b*NBUS + j];
            beat_cyc(fd);
        end
    endtask

    function automatic logic [NB-1:0] rnd_beat();
        logic [NB-1:0] fd;
        for (int j = 0; j < NBUS; j++) fd[j*IW +: IW] = rnd_word();
        return fd;
    endfunction

    // Monitor: pops status every cycle and a response whenever vld or nack is up.
    initial begin
        rsp_t            r;
        st_t             s;
        logic [NBUS-1:0] ep;
        int              pc;
        pc = 0;
        forever begin
            @(posedge l2clk);
            #1;
            if (arst) begin
                pc = 0;
                continue;
            end
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("fill_busy", NB'(fill_busy), NB'(s.busy));
                chk("fill_ovr", NB'(fill_ovr), NB'(s.ovr));
            end
            ep = '0;
            if (icd_vld_c || icd_nack_c) begin
                if (rsp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rsp: vld=%b nack=%b, required no response", icd_vld_c, icd_nack_c);
                end else begin
                    r = rsp_q.pop_front();
                    chk("icd_vld_c", NB'(icd_vld_c), NB'(!r.nack));
                    chk("icd_nack_c", NB'(icd_nack_c), NB'(r.nack));
                    chk("icd_instr_c", icd_instr_c, r.data);
                    if (!r.nack)
                        for (int i = 0; i < NBUS; i++) ep[i] = PERR_ON & (^r.data[i*IW +: IW]);
                end
            end
            chk("icd_perr_c", NB'(icd_perr_c), NB'(ep));
            chk("icd_perr_cnt", NB'(icd_perr_cnt), NB'(pc));
            pc = pc + $countones(ep);
            if (pc > 255) pc = 255;
        end
    end

    initial begin
        logic [NB-1:0] d0;
        logic [NB-1:0] exp5;
        fill_start_bf = 0; fill_index_bf = '0; fill_way_bf = '0; fill_vld_bf = 0;
        fill_data_bf = '0; rd_req_bf = 0; rd_index_bf = '0; rd_grp_bf = '0; waysel_c = '0;
        m_busy = 0; m_cnt = 0; m_idx = 0; m_way = 0;
        for (int w = 0; w < WAYS; w++) m_creg[w] = '0;

        #2;
        chk("rst_busy", NB'(fill_busy), '0);
        chk("rst_ovr", NB'(fill_ovr), '0);
        chk("rst_vld", NB'(icd_vld_c), '0);
        chk("rst_nack", NB'(icd_nack_c), '0);
        chk("rst_instr", icd_instr_c, '0);
        chk("rst_perr_cnt", NB'(icd_perr_cnt), '0);
        @(negedge l2clk);
        arst = 0;

        for (int s = 0; s < NS; s++)
            for (int w = 0; w < WAYS; w++) fill_line(s, w, 0);

        // Fill set 5 way 3 with 0x10..0x17 then read group 1 through way 3.
        fill_line(5, 3, 1);
        rd(5, 1, 8'h08);
        @(posedge l2clk); #2;
        exp5 = {33'h17, 33'h16, 33'h15, 33'h14};
        chk("s5_grp1_instr", icd_instr_c, exp5);
        chk("s5_grp1_vld", NB'(icd_vld_c), NB'(1'b1));

        // Collision: read with beat 0 is nacked, the retry sees the new words.
        drive(1, 6, 2, 0, '0, 0, 0, 0, '0);
        drive(0, 0, 0, 1, rnd_beat(), 1, 6, 0, 8'h04);
        drive(0, 0, 0, 1, rnd_beat(), 1, 6, 0, 8'h04);
        rd(6, 1, 8'h04);

        // Overrun: second start mid-fill is ignored and the first fill completes.
        drive(1, 3, 4, 0, '0, 0, 0, 0, '0);
        drive(1, 2, 5, 1, rnd_beat(), 0, 0, 0, '0);
        beat_cyc(rnd_beat());
        idle_cyc();
        rd(3, 0, 8'h10); rd(3, 1, 8'h10); rd(2, 0, 8'h20); rd(2, 1, 8'h20);

        // Reset after beat 0: beat 0 stays written, beat 1 keeps the old words.
        drive(1, 4, 1, 0, '0, 0, 0, 0, '0);
        d0 = rnd_beat();
        beat_cyc(d0);
        @(posedge l2clk); #3;
        arst = 1;
        #1;
        chk("midrst_busy", NB'(fill_busy), '0);
        chk("midrst_vld", NB'(icd_vld_c), '0);
        chk("midrst_instr", icd_instr_c, '0);
        chk("midrst_perr_cnt", NB'(icd_perr_cnt), '0);
        @(negedge l2clk);
        fill_vld_bf = 0; fill_start_bf = 0; rd_req_bf = 0;
        @(posedge l2clk);
        @(negedge l2clk);
        arst = 0;
        m_busy = 0; m_cnt = 0;
        for (int w = 0; w < WAYS; w++) m_creg[w] = '0;
        rd(4, 0, 8'h02);
        rd(4, 1, 8'h02);

`ifdef ICD_PERR_EN
        fill_line(7, 0, 2);
        rd(7, 0, 8'h01);
        @(posedge l2clk); #2;
        chk("perr_word2", NB'(icd_perr_c), NB'(4'b0100));
        for (int k = 0; k < 299; k++) rd(7, 0, 8'h01);
        idle_cyc();
        @(posedge l2clk); #2;
        chk("perr_cnt_sat", NB'(icd_perr_cnt), NB'(8'd255));
`endif

        for (int c = 0; c < 1500; c++) begin
            int  rsel;
            logic [WAYS-1:0] ws;
            rsel = int'($urandom_range(0, 7));
            ws = (rsel == 0) ? '0 : (rsel == 1) ? WAYS'($urandom) : WAYS'(1) << $urandom_range(0, WAYS - 1);
            drive(($urandom % 100) < (m_busy ? 10 : 30), int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, WAYS - 1)), ($urandom % 100) < 70, rnd_beat(),
                  ($urandom % 100) < 60, int'($urandom_range(0, NS - 1)),
                  int'($urandom_range(0, BEATS - 1)), ws);
        end
        while (m_busy) beat_cyc(rnd_beat());
        idle_cyc();
        idle_cyc();
        @(negedge l2clk);
        chk("rsp_q_drained", NB'(rsp_q.size()), '0);
        chk("st_q_drained", NB'(st_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/n2_icd_sp_param_cust.md
# n2_icd_sp_param_cust

Parametrised instruction-cache data array for the SPC front end. It generalises the fixed 8-way, 4-bus icache data macro to configurable ways, sets, line size and fetch width. It adds a multi-beat line-fill sequencer, read/fill arbitration and optional parity checking. It sits between the fetch-address pipeline (bf stage) and the instruction buffer (c stage).

## Interface

Parameters:
- WAYS, 8: associativity.
- SETS, 128: sets per way; must be a power of 2.
- LINE_WORDS, 8: 33-bit instruction words per line.
- NBUS, 4: words returned per read; LINE_WORDS/NBUS = BEATS, a power of 2.
- IW, 33: word width, 32 data bits plus 1 even-parity bit.

Ports:
- l2clk  in  1  sole clock; all flops on rising edge.
- arst  in  1  asynchronous, active-high reset.
- rd_req_bf  in  1  read request.
- rd_index_bf  in  log2(SETS)  read set.
- rd_grp_bf  in  log2(BEATS) (min 1)  word group within line.
- waysel_c  in  WAYS  one-hot late way select, c stage.
- fill_start_bf  in  1  begin line fill.
- fill_index_bf  in  log2(SETS)  fill set.
- fill_way_bf  in  log2(WAYS)  fill way.
- fill_vld_bf  in  1  fill data beat valid.
- fill_data_bf  in  NBUS*IW  beat data; word 0 in LSBs.
- fill_busy  out  1  fill in progress.
- fill_ovr  out  1  one-cycle pulse: fill_start_bf ignored while busy.
- icd_instr_c  out  NBUS*IW  selected instruction words.
- icd_vld_c  out  1  c-stage read data valid.
- icd_nack_c  out  1  read dropped because of beat-write collision.
- icd_perr_c  out  NBUS  per-word parity error (ICD_PERR_EN only).
- icd_perr_cnt  out  8  saturating parity-error count (ICD_PERR_EN only).

## Operation

- Storage: SETS x WAYS x LINE_WORDS words of IW bits. Array contents are not reset.
- FSM states are IDLE and FILL. Reset puts the FSM in IDLE.
- IDLE, fill_start_bf=1:
  - latch index and way; beat counter = 0; go to FILL.
  - fill_vld_bf in the same cycle is ignored.
- FILL, fill_vld_bf=1:
  - write fill_data_bf to words [cnt*NBUS +: NBUS] of the latched set and way.
  - increment cnt.
  - on the last beat (cnt=BEATS-1), return to IDLE.
- fill_vld_bf in IDLE: ignored.
- fill_start_bf in FILL: ignored; fill_ovr pulses for one cycle.
- fill_busy = (state==FILL).
- Read, no write beat in the same cycle:
  - all WAYS entries of words [grp*NBUS +: NBUS] at rd_index_bf are registered into per-way c-stage registers.
  - icd_vld_c=1 the next cycle.
- Read in the same cycle as a write beat: the write wins and the read is dropped. Next cycle: icd_vld_c=0, icd_nack_c=1, c-stage registers hold their values.
- Reads to a set mid-fill are allowed and return the array contents as they stand (old and new words mixed). No hazard protection.
- icd_instr_c is the combinational OR over the ways enabled by waysel_c of the c-stage registers:
  - waysel_c=0 gives all zeros.
  - multi-hot gives the OR of the enabled ways; this is legal, but the result is not meaningful.
- icd_instr_c is driven regardless of icd_vld_c.
- Reset values: all outputs 0, c-stage registers 0, cnt 0.
- Reset asserted mid-fill: the FSM goes to IDLE; words already written stay in the array.

## Timing

- Read latency: request at edge N; data is valid in the cycle after edge N. waysel_c applies combinationally in that cycle.
- Fill: a start at edge N allows the first beat at edge N+1 at the earliest. fill_busy falls in the cycle after the last-beat edge. Back-to-back fills need one IDLE cycle between them.
- A read in the cycle after a write beat sees the newly written data.
- icd_perr_c is combinational from the c-stage registers and waysel_c, gated by icd_vld_c. icd_perr_cnt updates at the following edge.

## Configuration

- ICD_PERR_EN defined:
  - icd_perr_c[i] = icd_vld_c & (^word i), with even parity over all IW bits.
  - icd_perr_cnt adds popcount(icd_perr_c) each cycle and saturates at 255. It is reset by arst.
- ICD_PERR_EN undefined: both outputs are tied to 0 and no checker or counter logic is built.

## Test plan

- Reset: assert arst mid-cycle -> all outputs 0 immediately and fill_busy=0; the array retains the words written before reset.
- Fill then read, default parameters: fill set 5, way 3 with 2 beats (words 0..7 = 0x0_0000_0010..17). Then read set 5, grp 1, waysel_c=0x08 -> icd_instr_c holds 0x14..0x17 and icd_vld_c=1 one cycle after the request.
- Collision: rd_req_bf together with fill_vld_bf -> next cycle icd_nack_c=1 and icd_vld_c=0. Repeating the read one cycle later returns the new data.
- Overrun: fill_start_bf during FILL -> fill_ovr=1 for exactly one cycle; the latched index and way are unchanged; the fill completes normally.
- Reset mid-fill: arst after beat 0 -> FSM returns to IDLE. A read of grp 0 returns the new data; a read of grp 1 returns the old data.
- Parity (ICD_PERR_EN): write word 2 with odd parity, then read -> icd_perr_c=4'b0100 and icd_perr_cnt increments by 1. Repeat 300 times -> icd_perr_cnt=255.
